// File: rtl/glitch_cfg_pkg.sv
// Shared command codes, protocol bytes and parser states for the glitch configuration UART.
package glitch_cfg_pkg;

  typedef enum logic [7:0] {
    CMD_FORM  = 8'h01,
    CMD_DELAY = 8'h02,
    CMD_MATCH = 8'h03
  } cmd_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [1:0] {IDLE, CMD, DATA, CSUM} state_e;

  // Payload length in bytes for a command; 0 marks an unknown command.
  function automatic logic [3:0] cmd_len(input logic [7:0] cmd);
    case (cmd)
      CMD_FORM, CMD_DELAY: cmd_len = 4'd8;
      CMD_MATCH:           cmd_len = 4'd4;
      default:             cmd_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/glitch_cfg_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampler, byte and framing-error pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_vld,
  output logic       frame_err
);
  // byte_vld is a single-cycle strobe with no back-pressure; data holds until the next byte.
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_e;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_e     st;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= RX_IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_d      <= rx_s2;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (st)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            st  <= RX_START;
            cnt <= '0;
          end
        end
        RX_START: begin
          // A start bit that is no longer low at its midpoint was a glitch.
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_s2 ? RX_IDLE : RX_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s2) begin
              byte_vld <= 1'b1;
              data     <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/glitch_cfg_uart.sv
// Framed UART command receiver committing glitch form/delay/match registers atomically.
// Define GLITCH_CFG_ACK_EN to add the ACK/NAK transmitter on tx; otherwise tx idles high.
module glitch_cfg_uart
  import glitch_cfg_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic [63:0] cfg_form,
  output logic [63:0] cfg_delay,
  output logic [31:0] cfg_match,
  output logic        cfg_update,
  output logic        cfg_err
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0]    rx_data;
  logic          byte_vld, frame_err;
  state_e        state;
  cmd_e          tgt;
  logic [63:0]   shadow;
  logic [7:0]    csum;
  logic [3:0]    remain;
  logic [TW-1:0] tmo_cnt;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_data),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tgt        <= CMD_FORM;
      shadow     <= '0;
      csum       <= '0;
      remain     <= '0;
      tmo_cnt    <= '0;
      cfg_form   <= '0;
      cfg_delay  <= '0;
      cfg_match  <= '0;
      cfg_update <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      cfg_err    <= 1'b0;
      if (frame_err) begin
        state   <= IDLE;
        cfg_err <= 1'b1;
        tmo_cnt <= '0;
      end else if (byte_vld) begin
        // A byte arriving on the timeout cycle takes priority and restarts the count.
        tmo_cnt <= '0;
        case (state)
          IDLE: if (rx_data == SYNC_BYTE) state <= CMD;
          CMD: begin
            if (cmd_len(rx_data) == 4'd0) begin
              state   <= IDLE;
              cfg_err <= 1'b1;
            end else begin
              state  <= DATA;
              remain <= cmd_len(rx_data);
              shadow <= '0;
              csum   <= rx_data;
              tgt    <= cmd_e'(rx_data);
            end
          end
          DATA: begin
            shadow <= {shadow[55:0], rx_data};
            csum   <= csum ^ rx_data;
            remain <= remain - 1'b1;
            if (remain == 4'd1) state <= CSUM;
          end
          CSUM: begin
            state <= IDLE;
            if (rx_data == csum) begin
              cfg_update <= 1'b1;
              case (tgt)
                CMD_FORM:  cfg_form  <= shadow;
                CMD_DELAY: cfg_delay <= shadow;
                default:   cfg_match <= shadow[31:0];
              endcase
            end else begin
              cfg_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        state   <= IDLE;
        cfg_err <= 1'b1;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

`ifdef GLITCH_CFG_ACK_EN
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

  logic          pend_vld;
  logic [7:0]    pend_byte;
  logic          tx_busy;
  logic          tx_q;
  logic [9:0]    tx_shift;
  logic [3:0]    tx_bits;
  logic [BW-1:0] tx_cnt;

  // Single pending slot: a newer status overwrites an unsent one, so RX never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      tx_busy   <= 1'b0;
      tx_q      <= 1'b1;
      tx_shift  <= '1;
      tx_bits   <= '0;
      tx_cnt    <= '0;
    end else begin
      if (!tx_busy) begin
        if (pend_vld) begin
          tx_busy  <= 1'b1;
          tx_shift <= {1'b1, pend_byte, 1'b0};
          tx_q     <= 1'b0;
          tx_bits  <= '0;
          tx_cnt   <= '0;
          pend_vld <= 1'b0;
        end
      end else if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
          tx_q    <= 1'b1;
        end else begin
          tx_bits  <= tx_bits + 1'b1;
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_q     <= tx_shift[1];
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (cfg_update) begin
        pend_vld  <= 1'b1;
        pend_byte <= ACK_BYTE;
      end else if (cfg_err) begin
        pend_vld  <= 1'b1;
        pend_byte <= NAK_BYTE;
      end
    end
  end

  assign tx = tx_q;
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_glitch_cfg_uart.sv
// Bench for glitch_cfg_uart: frame-level reference model, expected-event queue and event monitor.
module tb_glitch_cfg_uart;
  localparam int CPB = 16;
  localparam int TMO = 2000;
  localparam int W   = 161;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [63:0] cfg_form, cfg_delay;
  logic [31:0] cfg_match;
  logic        cfg_update, cfg_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   ack_q[$];
  logic [63:0]  m_form = '0, m_delay = '0;
  logic [31:0]  m_match = '0;
  logic [63:0]  shown_form = '0, shown_delay = '0;
  logic [31:0]  shown_match = '0;

  glitch_cfg_uart #(.CLK_HZ(1_600_000), .BAUD(100_000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .tx         (tx),
    .cfg_form   (cfg_form),
    .cfg_delay  (cfg_delay),
    .cfg_match  (cfg_match),
    .cfg_update (cfg_update),
    .cfg_err    (cfg_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, %0d expectations left", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_err();
    exp_q.push_back({1'b0, m_form, m_delay, m_match});
  endtask

  // Reference model: interprets one complete byte sequence as a frame.
  task automatic model_frame(input bq_t fr);
    int i = 0;
    int n;
    logic [7:0]  cmd, x;
    logic [63:0] val;
    while (i < fr.size() && fr[i] != 8'hA5) i++;
    if (i + 1 >= fr.size()) return;
    cmd = fr[i+1];
    n = (cmd == 8'h01 || cmd == 8'h02) ? 8 : (cmd == 8'h03) ? 4 : 0;
    if (n == 0) begin
      push_err();
      return;
    end
    if (fr.size() < i + 3 + n) return;
    val = '0;
    x = cmd;
    for (int k = 0; k < n; k++) begin
      val = (val << 8) | 64'(fr[i+2+k]);
      x ^= fr[i+2+k];
    end
    if (fr[i+2+n] != x) begin
      push_err();
      return;
    end
    case (cmd)
      8'h01:   m_form = val;
      8'h02:   m_delay = val;
      default: m_match = val[31:0];
    endcase
    exp_q.push_back({1'b1, m_form, m_delay, m_match});
  endtask

  // driver tasks
  task automatic build(input logic [127:0] v, input int n, input bit add_csum, output bq_t q);
    logic [7:0] x = 8'h00;
    q.delete();
    for (int k = 0; k < n; k++) q.push_back(v[8*(n-1-k) +: 8]);
    if (add_csum) begin
      for (int k = 1; k < n; k++) x ^= q[k];
      q.push_back(x);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(posedge clk);
  endtask

  task automatic send_q(input bq_t fr, input int max_gap);
    foreach (fr[k]) begin
      send_byte(fr[k], 1'b1);
      repeat ($urandom_range(max_gap, 0)) @(posedge clk);
    end
  endtask

  task automatic do_frame(input logic [127:0] v, input int n, input bit add_csum, input int max_gap);
    bq_t fr;
    build(v, n, add_csum, fr);
    model_frame(fr);
    send_q(fr, max_gap);
  endtask

  // monitor: pops one expectation per update/err pulse, otherwise cfg must hold
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cfg_update || cfg_err) begin
          check("update_err_exclusive", W'(cfg_update & cfg_err), '0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: update=%b err=%b with nothing expected", cfg_update, cfg_err);
          end else begin
            e = exp_q.pop_front();
            check("event", {cfg_update, cfg_form, cfg_delay, cfg_match}, e);
            shown_form  = e[159:96];
            shown_delay = e[95:32];
            shown_match = e[31:0];
`ifdef GLITCH_CFG_ACK_EN
            ack_q.push_back(e[W-1] ? 8'h06 : 8'h15);
`endif
          end
        end else begin
          check("cfg_stable", {1'b0, cfg_form, cfg_delay, cfg_match},
                {1'b0, shown_form, shown_delay, shown_match});
        end
`ifndef GLITCH_CFG_ACK_EN
        check("tx_idle", W'(tx), W'(1'b1));
`endif
      end
    end
  end

`ifdef GLITCH_CFG_ACK_EN
  initial begin
    logic [7:0] got, want;
    logic       stop;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(posedge clk);
        got[k] = tx;
      end
      repeat (CPB) @(posedge clk);
      stop = tx;
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %h with nothing expected", got);
      end else begin
        want = ack_q.pop_front();
        check("ack_byte", W'({stop, got}), W'({1'b1, want}));
      end
    end
  end
`endif

  // stimulus
  initial begin
    bq_t fr;
    logic [7:0] b, x;
    int kind, cmd, n;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_cfg", {cfg_form, cfg_delay, cfg_match, cfg_update}, '0);
    check("reset_err_tx", W'({cfg_err, tx}), W'(2'b01));
    @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    do_frame(128'hA5_01_0123456789ABCDEF, 10, 1'b1, 5);
    do_frame(128'hA5_03_DEADBEEF, 6, 1'b1, 5);
    do_frame(128'hA5_02_00000000000000_10, 10, 1'b1, 5);
    do_frame(128'hA5_03_12345678_00, 7, 1'b0, 5);
    do_frame(128'hA5_07, 2, 1'b0, 5);
    do_frame(128'hA5_03_000000A5_A6, 7, 1'b0, 5);

    // leading noise bytes while idle are ignored
    build(128'hA5_02_1122334455667788, 10, 1'b1, fr);
    fr.push_front(8'h5A);
    fr.push_front(8'hFF);
    fr.push_front(8'h00);
    model_frame(fr);
    send_q(fr, 3);

    // short low pulse between data bytes must not become a byte
    build(128'hA5_03_CAFEF00D, 6, 1'b1, fr);
    model_frame(fr);
    for (int k = 0; k < 4; k++) send_byte(fr[k], 1'b1);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    for (int k = 4; k < 7; k++) send_byte(fr[k], 1'b1);

    do_frame(128'hA5_01_FEDCBA9876543210, 10, 1'b1, 0);
    do_frame(128'hA5_03_0BADCAFE, 6, 1'b1, 0);

    // inter-byte timeout; expectation posted late so an early abort is caught
    build(128'hA5_01_1122, 4, 1'b0, fr);
    send_q(fr, 0);
    repeat (TMO - 100) @(posedge clk);
    push_err();
    repeat (300) @(posedge clk);

    // stop bit sampled low on the checksum byte
    build(128'hA5_03_DEADBEEF, 6, 1'b0, fr);
    send_q(fr, 2);
    push_err();
    send_byte(8'h21, 1'b0);
    repeat (2 * CPB) @(posedge clk);

    // reset in the middle of a delay frame's data
    build(128'hA5_02_0000, 4, 1'b0, fr);
    send_q(fr, 2);
    @(posedge clk);
    rst = 1'b1;
    m_form = '0;
    m_delay = '0;
    m_match = '0;
    shown_form = '0;
    shown_delay = '0;
    shown_match = '0;
    repeat (3) @(negedge clk);
    check("reset_mid_frame_cfg", {cfg_form, cfg_delay, cfg_match, cfg_update}, '0);
    check("reset_mid_frame_err", W'(cfg_err), '0);
    @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    do_frame(128'hA5_02_0000000000C0FFEE, 10, 1'b1, 3);

    for (int r = 0; r < 16; r++) begin
      fr.delete();
      repeat ($urandom_range(2, 0)) begin
        do b = 8'($urandom); while (b == 8'hA5);
        fr.push_back(b);
      end
      kind = $urandom_range(9, 0);
      fr.push_back(8'hA5);
      if (kind == 0) begin
        do cmd = $urandom_range(255, 0); while (cmd >= 1 && cmd <= 3);
        fr.push_back(8'(cmd));
      end else begin
        cmd = $urandom_range(3, 1);
        fr.push_back(8'(cmd));
        n = (cmd == 3) ? 4 : 8;
        x = 8'(cmd);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          fr.push_back(b);
          x ^= b;
        end
        if (kind == 1) x ^= 8'($urandom_range(255, 1));
        fr.push_back(x);
      end
      model_frame(fr);
      send_q(fr, 30);
    end

    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    check("exp_q_drained", W'(exp_q.size()), '0);
`ifdef GLITCH_CFG_ACK_EN
    for (int t = 0; t < 3000 && ack_q.size() != 0; t++) @(posedge clk);
    check("ack_q_drained", W'(ack_q.size()), '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
